// File: rtl/burst_trigger_generator.sv
// Delay-then-burst trigger source for the pulse monoflop.
// Emits count strobes spaced max(period,2) clocks apart after a start delay.
module burst_trigger_generator #(
  parameter int PulseLengthWidth = 4,
  parameter int DelayWidth       = 16,
  parameter int PeriodWidth      = 16,
  parameter int CountWidth       = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DelayWidth-1:0]       delay,
  input  logic [PeriodWidth-1:0]      period,
  input  logic [CountWidth-1:0]       count,
  input  logic [PulseLengthWidth-1:0] pulselength_in,
  output logic                        trigger,
  output logic [PulseLengthWidth-1:0] pulselength,
  output logic                        busy,
  output logic                        done,
  output logic [CountWidth-1:0]       issued
);

  localparam int TimerWidth =
    (DelayWidth > PeriodWidth) ? DelayWidth : PeriodWidth;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    FIRE,
    GAP
  } state_t;

  state_t                  state;
  logic [TimerWidth-1:0]   timer;
  logic [PeriodWidth-1:0]  per_q;
  logic [CountWidth-1:0]   count_q;
  logic [PeriodWidth-1:0]  per_eff;
  logic [PeriodWidth-1:0]  gap_load;

  // Spacing below 2 would merge strobes into a level the monoflop can't see.
  assign per_eff  = (period < PeriodWidth'(2)) ? PeriodWidth'(2) : period;
  assign gap_load = per_q - PeriodWidth'(2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      per_q       <= '0;
      count_q     <= '0;
      trigger     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulselength <= '0;
      issued      <= '0;
    end else begin
      trigger <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        if (enable && start) begin
          per_q       <= per_eff;
          count_q     <= count;
          pulselength <= pulselength_in;
          issued      <= '0;
          if (count == '0) begin
            done <= 1'b1;
          end else begin
            state <= DELAY;
            timer <= TimerWidth'(delay);
            busy  <= 1'b1;
          end
        end
      end else if (enable) begin
        unique case (state)
          DELAY, GAP: begin
            if (timer == '0) begin
              state   <= FIRE;
              trigger <= 1'b1;
              issued  <= issued + 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          FIRE: begin
            if (issued == count_q) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= GAP;
              timer <= TimerWidth'(gap_load);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/burst_trigger_generator.md
Name: burst_trigger_generator

Overview:
- Upstream driver for the pulse monoflop stage: on a start request, waits a programmable delay, then emits a burst of N single-cycle trigger strobes spaced a programmable period apart.
- Presents a pulse length that is held stable for the whole burst.
- Outputs `trigger` and `pulselength` connect directly to the monoflop's trigger and pulse-length inputs.
- Lets the sequencer fire repeated fixed-width pulses without per-pulse software involvement.

Parameters:
- PulseLengthWidth, 4, width of the pulse-length field passed through to the monoflop
- DelayWidth, 16, width of the start-to-first-trigger delay counter
- PeriodWidth, 16, width of the trigger-to-trigger period counter
- CountWidth, 16, width of the burst pulse count

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global run enable; low freezes all timers and state
- start  in  1  synchronous request to begin a burst; sampled only in IDLE
- abort  in  1  synchronous request to terminate the burst immediately
- delay  in  DelayWidth  clocks from start to first trigger, latched at start
- period  in  PeriodWidth  trigger spacing in clocks, latched at start
- count  in  CountWidth  number of triggers in the burst, latched at start
- pulselength_in  in  PulseLengthWidth  pulse length for this burst, latched at start
- trigger  out  1  registered one-clock strobe, one per pulse
- pulselength  out  PulseLengthWidth  latched pulse length, stable from start acceptance until the next accepted start
- busy  out  1  high from the cycle after start acceptance until return to IDLE
- done  out  1  one-clock strobe when a burst completes normally
- issued  out  CountWidth  triggers emitted in the current or last burst

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; trigger, busy, done = 0; pulselength, issued = 0; all timers = 0.
  - Reset asserted mid-burst aborts the burst with no done.
- States: IDLE, DELAY, FIRE, GAP.
- Start acceptance:
  - Accepted when state = IDLE, enable = 1, start = 1, abort = 0.
  - At that edge: latch delay, count, pulselength_in, and eff_period = max(period, 2); clear issued to 0.
  - If count = 0: stay IDLE, done = 1 for one clock, busy stays 0.
  - Otherwise go to DELAY with timer = delay.
- DELAY: when timer = 0, go to FIRE; otherwise decrement timer.
  - First trigger is high in the clock cycle beginning delay+1 edges after the accepting edge. With delay = 0, trigger is high in the 2nd cycle after start.
- FIRE: trigger = 1 for exactly one clock; issued increments by 1.
  - If issued (new value) = latched count: go to IDLE and pulse done = 1 in that same IDLE-entry cycle, with busy = 0.
  - Otherwise go to GAP with timer = eff_period - 2.
- GAP: when timer = 0, go to FIRE; otherwise decrement timer.
  - Rising edges of trigger are exactly eff_period clocks apart.
  - trigger is always low for at least 1 clock between strobes, because the monoflop is edge-triggered.
- enable = 0 in any non-IDLE state: hold state, timer and issued; trigger forced low. Resuming continues where the burst stopped.
- abort = 1 (any state, regardless of enable):
  - Next state = IDLE; trigger and busy low at the next edge; done not pulsed.
  - issued retains its value; pulselength holds.
  - abort beats start in the same cycle.
- start while busy is ignored; it is not queued.
- trigger, busy and done are registered outputs with no combinational path from inputs.
- Arithmetic:
  - Counters are unsigned.
  - Maximum count is 2^CountWidth-1; issued never wraps.
  - eff_period - 2 is computed at PeriodWidth width and never underflows because of the clamp.

Test Plan:
- Single pulse: delay=0, count=1, period=5, pulselength_in=7, start at edge 0 -> trigger high in cycle 2 only, pulselength=7, done high in cycle 3, busy high cycles 1-2, issued=1.
- Burst spacing: delay=3, count=4, period=6 -> triggers at cycles 5, 11, 17, 23; done at 24; issued=4.
- Period clamp: period=0 and period=1 with count=3, delay=0 -> triggers at cycles 2, 4, 6 (spacing 2, trigger low between).
- Zero count: count=0 -> no trigger, busy never high, done high one cycle after start.
- Abort and freeze:
  - enable low for 5 cycles during GAP -> all later triggers shifted by exactly 5.
  - abort during DELAY of a second burst -> no trigger, no done, busy low next cycle, start during busy ignored.
- Async reset: assert reset_n low mid-GAP between clock edges -> all outputs 0 immediately. After release, a new start behaves as in the single-pulse case.
